// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: word width, FSM states
// and the byte-address to word-index rule.
package wisc_mem_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // Byte address to word index; callers truncate to their array depth, which
  // is what makes higher address bits alias.
  function automatic logic [14:0] word_index(input logic [15:0] byte_addr);
    return 15'(byte_addr >> 1);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the Memory stage and the data-memory
// responder.
interface data_mem_responder_if;

  logic                           enable;
  logic                           wr;
  logic [15:0]                    addr;
  logic [wisc_mem_pkg::WORD_W-1:0] data_in;
  logic [wisc_mem_pkg::WORD_W-1:0] data_out;
  logic                           data_valid;
  logic                           stall;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, stall
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, stall
  );

endinterface

// File: rtl/data_mem_responder_mem_array.sv
// Synchronous single-port word RAM with a registered read port that only
// updates on reads, so it doubles as the responder's load-result register.
module mem_array
  import wisc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  // Contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store, stalls the pipeline for
// LATENCY cycles, then executes the access and pulses data_valid.
module data_mem_responder
  import wisc_mem_pkg::*;
#(
  parameter int unsigned MEM_ADDR_W = 13,
  parameter int unsigned LATENCY    = 4
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  mem_state_t            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  accept;
  logic                  exec;
  logic                  wr_q;
  logic [MEM_ADDR_W-1:0] idx_q;
  logic [WORD_W-1:0]     wdata_q;
  logic                  valid_q;
  logic [WORD_W-1:0]     rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    exec    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.enable) begin
          accept  = 1'b1;
          cnt_d   = 4'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          exec    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= exec;
    end
  end

  // Request fields are only captured on acceptance, never while BUSY.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      wr_q    <= bus.wr;
      idx_q   <= MEM_ADDR_W'(word_index(bus.addr));
      wdata_q <= bus.data_in;
    end
  end

  // A reset on the executing edge must not let a pending store commit.
  mem_array #(
    .ADDR_W(MEM_ADDR_W)
  ) u_mem_array (
    .clk  (clk),
    .rst  (rst),
    .en   (exec && !rst),
    .we   (wr_q),
    .idx  (idx_q),
    .wdata(wdata_q),
    .rdata(rdata)
  );

  assign bus.data_out   = rdata;
  assign bus.data_valid = valid_q;
  assign bus.stall      = (state_q == BUSY);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a timestamp-based reference
// model compared against the DUT every cycle.
module tb_data_mem_responder;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_responder_if bus_if ();

  data_mem_responder #(
    .MEM_ADDR_W(13),
    .LATENCY   (LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: requests are timestamped, completion is due LAT edges later.
  logic [15:0] mm [8192];
  bit          mv [8192];
  int          cyc = 0;
  bit          live = 0;
  bit          m_busy = 0;
  int          m_done = 0;
  int          m_valid_cyc = -1;
  bit          m_wr;
  int          m_idx;
  logic [15:0] m_wdata;
  logic [15:0] m_dout = '0;
  bit          m_dout_known = 1;

  always @(posedge clk) begin
    cyc++;
    live = 1;
    if (rst) begin
      m_busy = 0;
      m_valid_cyc = -1;
      m_dout = '0;
      m_dout_known = 1;
    end else if (m_busy && cyc == m_done) begin
      if (m_wr) begin
        mm[m_idx] = m_wdata;
        mv[m_idx] = 1;
      end else begin
        m_dout = mm[m_idx];
        m_dout_known = mv[m_idx];
      end
      m_busy = 0;
      m_valid_cyc = cyc;
    end else if (!m_busy && bus_if.enable) begin
      m_busy  = 1;
      m_done  = cyc + LAT;
      m_wr    = bus_if.wr;
      m_idx   = (int'(bus_if.addr) / 2) % 8192;
      m_wdata = bus_if.data_in;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("cmp_valid", 32'(bus_if.data_valid), 32'(m_valid_cyc == cyc));
      check("cmp_stall", 32'(bus_if.stall), 32'(m_busy));
      if (m_dout_known) check("cmp_dout", 32'(bus_if.data_out), 32'(m_dout));
    end
  end

  task automatic req(input logic w, input logic [15:0] a, input logic [15:0] d, input bit hold);
    int n_stall = 0;
    bit got = 0;
    @(negedge clk);
    bus_if.enable = 1'b1; bus_if.wr = w; bus_if.addr = a; bus_if.data_in = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (hold) bus_if.wr = 1'b0;
      else bus_if.enable = 1'b0;
      if (bus_if.data_valid) begin
        bus_if.enable = 1'b0;
        got = 1;
      end else if (bus_if.stall) begin
        n_stall++;
      end
    end
    bus_if.enable = 1'b0;
    check("req_stall_len", 32'(n_stall), 32'(LAT));
    check("req_valid_seen", 32'(got), 32'd1);
  endtask

  task automatic count_valid(input int n, output int nv);
    nv = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus_if.data_valid) nv++;
    end
  endtask

  initial begin
    int nv;
    rst = 1'b1;
    bus_if.enable = 1'b1; bus_if.wr = 1'b1; bus_if.addr = 16'h00A4; bus_if.data_in = 16'h1234;
    repeat (2) begin
      @(negedge clk);
      check("rst_dout", 32'(bus_if.data_out), 32'h0);
      check("rst_valid", 32'(bus_if.data_valid), 32'h0);
      check("rst_stall", 32'(bus_if.stall), 32'h0);
    end
    rst = 1'b0;
    bus_if.enable = 1'b0;

    req(1'b1, 16'h00A4, 16'hBEEF, 0);
    req(1'b0, 16'h00A4, 16'h0000, 0);
    check("load_a4", 32'(bus_if.data_out), 32'hBEEF);

    req(1'b1, 16'h0010, 16'h1234, 1);
    count_valid(6, nv);
    check("held_no_extra_valid", 32'(nv), 32'd0);
    req(1'b0, 16'h0010, 16'h0000, 0);
    check("load_10", 32'(bus_if.data_out), 32'h1234);

    req(1'b1, 16'h4002, 16'h5A5A, 0);
    req(1'b0, 16'h0003, 16'h0000, 0);
    check("alias_load", 32'(bus_if.data_out), 32'h5A5A);

    req(1'b1, 16'h0020, 16'h1111, 0);
    bus_if.enable = 1'b1; bus_if.wr = 1'b1; bus_if.addr = 16'h0020; bus_if.data_in = 16'hFFFF;
    @(negedge clk);
    bus_if.enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_dout", 32'(bus_if.data_out), 32'h0);
    count_valid(8, nv);
    check("midrst_no_valid", 32'(nv), 32'd0);
    req(1'b0, 16'h0020, 16'h0000, 0);
    check("load_20_kept", 32'(bus_if.data_out), 32'h1111);

    @(negedge clk);
    bus_if.enable = 1'b1; bus_if.wr = 1'b0; bus_if.addr = 16'h00A4;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("b2b_stall_vs_valid", 32'(bus_if.stall), 32'(!bus_if.data_valid));
      if (bus_if.data_valid) begin
        nv++;
        check("b2b_dout", 32'(bus_if.data_out), 32'hBEEF);
      end
    end
    bus_if.enable = 1'b0;
    check("b2b_pulses", 32'(nv), 32'd4);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the pipeline's data-memory port. It accepts one load or store request at a time from the Memory stage's `enable`/`wr`/`addr`/`data_in` outputs. It holds the request for a configurable latency, raising `stall` so the pipeline freezes, then returns read data on `data_out` with a one-cycle `data_valid` pulse. It sits outside the pipeline and is the only owner of the data array.

## Interface
Parameters:
- `MEM_ADDR_W`, default 13: word-index width; array holds 2**MEM_ADDR_W 16-bit words.
- `LATENCY`, default 4: cycles from accept to completion. Legal range is 1..15.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: request valid from the Memory stage.
- `wr` in 1: 1 = store, 0 = load. Sampled with `enable`.
- `addr` in 16: byte address. `addr[0]` is ignored. Word index is `addr[MEM_ADDR_W:1]`. Higher bits are ignored, so addresses alias.
- `data_in` in 16: store data, sampled with `enable`.
- `data_out` out 16: last load result.
- `data_valid` out 1: one-cycle completion pulse, for loads and stores.
- `stall` out 1: request in flight. Inputs are ignored while it is high.

## Operation
- States: IDLE and BUSY. A 4-bit down-counter `cnt` tracks BUSY time.
- IDLE:
  - `stall`=0.
  - If `enable`=1 at a rising edge, the responder latches `wr`, the word index, and `data_in`, loads `cnt`=LATENCY-1, and moves to BUSY.
- BUSY:
  - `stall`=1.
  - `enable`, `wr`, `addr`, and `data_in` are don't-care and are never latched.
  - At each edge, if `cnt`≠0 it decrements.
  - If `cnt`=0 at an edge, the access executes at that edge:
    - Store: the array word is written. `data_out` is unchanged.
    - Load: `data_out` ← array word.
  - On the executing edge, `data_valid` ← 1 and the state returns to IDLE.
- `data_valid` is 1 for exactly one cycle, the first IDLE cycle after BUSY. It is 0 in every other cycle.
- A request can be presented in the `data_valid` cycle. It is accepted at the end of that cycle. Throughput is one access per LATENCY+1 cycles.
- Store then load to the same word returns the new data, because the store commits before the next request can be accepted.
- Reset, in any state:
  - State → IDLE, `cnt`=0, `stall`=0, `data_valid`=0, `data_out`=16'h0000.
  - An in-flight access is discarded. A pending store does not modify the array.
  - Array contents are not reset.
- If `rst` and `enable` are both high at the same edge, reset wins and nothing is accepted.

## Timing
- Request sampled at edge T. `stall`=1 in cycles T..T+LATENCY-1.
- Access executes at edge T+LATENCY. In cycle T+LATENCY, `data_valid`=1 and `stall`=0, and `data_out` holds the load data.
- With LATENCY=1, `stall` is high for exactly one cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `wisc_mem_pkg` holds:
  - `WORD_W` = 16.
  - `mem_state_t` enum {IDLE, BUSY}.
  - The byte-to-word index rule, as a function.
- Sub-module `mem_array`: a synchronous single-port 2**MEM_ADDR_W × 16 RAM.
  - Inputs: `we`, `idx`, `wdata`. Output: registered `rdata`.
  - One read or write per edge.
  - Instantiated once. Its access strobe is the executing edge.

## Test plan
All scenarios use LATENCY=4 and MEM_ADDR_W=13.
- Reset: hold `rst`=1 for 2 cycles with `enable`=1 → `data_out`=0, `data_valid`=0, `stall`=0 throughout.
- Store 0x00A4←0xBEEF, then load 0x00A4 → for each request, `stall` is high for 4 cycles and `data_valid` pulses once at T+4. The load gives `data_out`=0xBEEF.
- Store 0x0010←0x1234, then hold `enable`=1 with a load of 0x0010 during `stall` → the held request is not accepted. Exactly one `data_valid` at T+4. A later load of 0x0010 returns 0x1234.
- Aliasing: store 0x4002←0x5A5A, then load 0x0003 → `data_out`=0x5A5A. Both addresses map to index 1.
- Reset mid-store: store 0x0020←0x1111 and let it complete. Then store 0x0020←0xFFFF and assert `rst` at T+2 → no `data_valid` follows. A subsequent load of 0x0020 returns 0x1111.
- Back-to-back: hold `enable`=1 with loads of 0x00A4 for 20 cycles → `data_valid` every 5 cycles, `stall` low only in `data_valid` cycles, `data_out`=0xBEEF on each pulse.
